dmd_frame_loader: RTL and testbench
===================================

DMD_FRAME_LOADER -- requirements
Module: dmd_frame_loader

Interface
REQ-001 Parameter H_PIX, default 128: DMD frame width in pixels.
REQ-002 Parameter V_PIX, default 32: DMD frame height in pixels.
REQ-003 Parameter ADDR_W, default 12: pixel address width; 2^ADDR_W SHALL equal H_PIX*V_PIX.
REQ-004 Parameter SYNC_BYTE, default 8'hA5: packet start marker.
REQ-005 Parameter TIMEOUT, default 35000: maximum idle clocks between bytes inside a packet (1 ms at 35 MHz).
REQ-006 clk  in  1  pixel clock; the only clock.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 rx_data  in  8  received byte from the serial receiver.
REQ-009 rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-010 vsync  in  1  vertical sync level from the video generator, active-high.
REQ-011 wr_en  out  1  frame-RAM write strobe.
REQ-012 wr_addr  out  ADDR_W+1  {bank, pixel index}; MSB is the bank bit.
REQ-013 wr_data  out  8  pixel byte written to the frame RAM.
REQ-014 front_bank  out  1  bank the video generator displays.
REQ-015 frame_done  out  1  one-cycle pulse when a completed frame is swapped to the front.
REQ-016 err  out  1  one-cycle pulse on a protocol error, timeout or overrun.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, HDR, LOAD and WAIT_SWAP.
REQ-019 In IDLE, an rx_valid byte equal to SYNC_BYTE SHALL move the FSM to HDR; any other byte SHALL be ignored without pulsing err.
REQ-020 In HDR, byte 8'h01 SHALL clear the pixel counter and move the FSM to LOAD.
REQ-021 In HDR, byte 8'h02 SHALL request a swap without new data, moving the FSM to WAIT_SWAP.
REQ-022 In HDR, any other byte SHALL pulse err and return the FSM to IDLE.
REQ-023 In LOAD, each rx_valid SHALL assert wr_en in the next cycle (latency 1), with wr_data = rx_data and wr_addr = {~front_bank, counter}, and SHALL then increment the counter.
REQ-024 The frame RAM SHALL never be written at the front bank.
REQ-025 When the write of index 2^ADDR_W-1 is issued, the counter SHALL wrap to 0 and the FSM SHALL move to WAIT_SWAP.
REQ-026 vsync SHALL be registered once; a rising edge is registered vsync high while the previous registered sample was low.
REQ-027 In WAIT_SWAP, on a vsync rising edge, front_bank SHALL toggle, frame_done SHALL pulse in the same cycle, and the FSM SHALL return to IDLE.
REQ-028 In WAIT_SWAP, any rx_valid SHALL be dropped and SHALL pulse err (overrun); the FSM SHALL keep waiting for the swap.
REQ-029 In HDR and LOAD, an idle counter SHALL count clocks since the last rx_valid and clear on every rx_valid.
REQ-030 When the idle counter reaches TIMEOUT, err SHALL pulse and the FSM SHALL return to IDLE without a swap; the partially written back bank is discarded.
REQ-031 If rx_valid arrives in the same cycle the idle counter reaches TIMEOUT, the byte SHALL take priority and no timeout SHALL occur.
REQ-032 In LOAD, a byte equal to SYNC_BYTE SHALL be treated as pixel data (no resynchronisation).
REQ-033 A vsync edge in any state other than WAIT_SWAP SHALL have no effect.
REQ-034 err and frame_done SHALL never be high for more than one cycle per event.

Reset
REQ-035 While rst_n is low: FSM = IDLE; wr_en, frame_done, err and busy = 0; wr_addr and wr_data = 0; front_bank = 0; all counters = 0; registered vsync = 0.
REQ-036 Reset asserted mid-LOAD SHALL abort immediately; no wr_en SHALL occur after rst_n falls.
REQ-037 After reset release, the first vsync rising edge is detected normally.

Verification
REQ-038 Full frame: send A5, 01 and 4096 bytes of value i[7:0]; then raise vsync -> 4096 writes with addr {1, i}, data i[7:0]; then front_bank=1 and one frame_done pulse.
REQ-039 Second frame after REQ-038 -> writes target bank 0 (wr_addr[12]=0); the next vsync edge gives front_bank=0.
REQ-040 Bad header: send A5, 7F -> err pulses once, busy=0, no wr_en.
REQ-041 Timeout: send A5, 01, 10 bytes, then silence for 35000 clocks -> err pulses once, FSM in IDLE, front_bank unchanged; the next frame restarts at index 0.
REQ-042 Overrun: complete a frame, send 3 bytes before vsync -> 3 err pulses, no wr_en; the swap still occurs on vsync.
REQ-043 Reset mid-LOAD after 100 bytes -> outputs at reset values; A5 01 is then accepted with writes starting at {1, 0}.

Source files
------------

// File: rtl/dmd_frame_loader.sv
// rtl/dmd_frame_loader.sv - DMD frame loader: serial packets into a double-buffered frame RAM
//
// Purpose: parses packets from a byte receiver. A5 01 <H_PIX*V_PIX bytes> fills the
// back bank of a two-bank frame RAM; A5 02 requests a swap without new data. Either
// way the banks swap on the next vsync rising edge.
//
// Ports:
//   clk         in   pixel clock
//   rst_n       in   asynchronous active-low reset
//   rx_data     in   received byte
//   rx_valid    in   one-cycle strobe qualifying rx_data
//   vsync       in   vertical sync level, active-high
//   wr_en       out  frame-RAM write strobe
//   wr_addr     out  {bank, pixel index}
//   wr_data     out  pixel byte
//   front_bank  out  bank currently displayed
//   frame_done  out  one-cycle pulse on a bank swap
//   err         out  one-cycle pulse on bad header, timeout or overrun
//   busy        out  high whenever the FSM is not idle

module dmd_frame_loader #(
   parameter int          H_PIX     = 128,
   parameter int          V_PIX     = 32,
   parameter int          ADDR_W    = 12,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int          TIMEOUT   = 35000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              vsync,
   output logic              wr_en,
   output logic [ADDR_W:0]   wr_addr,
   output logic [7:0]        wr_data,
   output logic              front_bank,
   output logic              frame_done,
   output logic              err,
   output logic              busy
);

   localparam int                IDLE_W   = $clog2(TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] TIMEOUT_C = IDLE_W'(TIMEOUT);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(H_PIX * V_PIX - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_HDR       = 2'd1,
      S_LOAD      = 2'd2,
      S_WAIT_SWAP = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [IDLE_W-1:0]   idle_q, idle_d;
   logic                vsync_q, vsync_prev_q;
   logic                front_q, front_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W:0]     wr_addr_q, wr_addr_d;
   logic [7:0]          wr_data_q, wr_data_d;
   logic                frame_done_q, frame_done_d;
   logic                err_q, err_d;
   logic                vsync_rise;

   assign vsync_rise = vsync_q & ~vsync_prev_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idle_d       = idle_q;
      front_d      = front_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;
      err_d        = 1'b0;

      case (state_q)
         S_IDLE: begin
            idle_d = '0;
            if (rx_valid && rx_data == SYNC_BYTE) begin
               state_d = S_HDR;
            end
         end

         S_HDR: begin
            if (rx_valid) begin
               idle_d = '0;
               if (rx_data == 8'h01) begin
                  cnt_d   = '0;
                  state_d = S_LOAD;
               end else if (rx_data == 8'h02) begin
                  state_d = S_WAIT_SWAP;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end else if (idle_q == TIMEOUT_C) begin
               err_d   = 1'b1;
               idle_d  = '0;
               state_d = S_IDLE;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end

         S_LOAD: begin
            // A byte arriving in the timeout cycle wins over the timeout.
            if (rx_valid) begin
               idle_d    = '0;
               wr_en_d   = 1'b1;
               wr_addr_d = {~front_q, cnt_q};
               wr_data_d = rx_data;
               if (cnt_q == LAST_IDX) begin
                  cnt_d   = '0;
                  state_d = S_WAIT_SWAP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (idle_q == TIMEOUT_C) begin
               err_d   = 1'b1;
               idle_d  = '0;
               state_d = S_IDLE;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end

         S_WAIT_SWAP: begin
            idle_d = '0;
            // Bytes here would overwrite the frame awaiting display: drop and flag.
            if (rx_valid) begin
               err_d = 1'b1;
            end
            if (vsync_rise) begin
               front_d      = ~front_q;
               frame_done_d = 1'b1;
               state_d      = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idle_q       <= '0;
         vsync_q      <= 1'b0;
         vsync_prev_q <= 1'b0;
         front_q      <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idle_q       <= idle_d;
         vsync_q      <= vsync;
         vsync_prev_q <= vsync_q;
         front_q      <= front_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign front_bank = front_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmd_frame_loader.sv
// tb/tb_dmd_frame_loader.sv - self-checking bench for dmd_frame_loader

module tb_dmd_frame_loader;

   localparam int NPIX = 4096;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        vsync;
   logic        wr_en;
   logic [12:0] wr_addr;
   logic [7:0]  wr_data;
   logic        front_bank;
   logic        frame_done;
   logic        err;
   logic        busy;

   dmd_frame_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .vsync      (vsync),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .front_bank (front_bank),
      .frame_done (frame_done),
      .err        (err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   int          err_cnt = 0;
   int          fd_cnt  = 0;
   int          wr_cnt  = 0;
   logic [31:0] sb[$];
   logic        exp_front = 1'b0;

   typedef struct {
      logic [7:0] hdr;
      int         exp_err;
      logic       exp_busy;
      logic       exp_swap;
   } hdr_vec_t;

   hdr_vec_t vecs[6];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard: every write is popped in order against what the stimulus pushed.
   always @(negedge clk) begin
      if (rst_n) begin
         if (err)        err_cnt++;
         if (frame_done) fd_cnt++;
         if (wr_en) begin
            wr_cnt++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
            end else begin
               check("write", {11'd0, wr_addr, wr_data}, sb.pop_front());
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_pix(input logic [11:0] idx, input logic [7:0] b);
      sb.push_back({11'd0, ~exp_front, idx, b});
      send(b);
   endtask

   task automatic pulse_vsync();
      vsync = 1'b1;
      tick(4);
      vsync = 1'b0;
      tick(4);
   endtask

   task automatic load_frame(input logic [7:0] seed);
      int w0;
      w0 = wr_cnt;
      send(8'hA5);
      send(8'h01);
      for (int i = 0; i < NPIX; i++) begin
         send_pix(12'(i), 8'(i) ^ seed);
      end
      tick(2);
      check("frame_writes", wr_cnt - w0, NPIX);
      check("frame_busy_wait", busy, 1);
      check("frame_sb_empty", sb.size(), 0);
   endtask

   task automatic swap_expect();
      int f0;
      f0 = fd_cnt;
      pulse_vsync();
      exp_front = ~exp_front;
      check("swap_frame_done", fd_cnt - f0, 1);
      check("swap_front", front_bank, exp_front);
      check("swap_busy", busy, 0);
   endtask

   initial begin
      int e0, w0, f0;
      vecs[0] = '{8'h02, 0, 1'b1, 1'b1};
      vecs[1] = '{8'h7F, 1, 1'b0, 1'b0};
      vecs[2] = '{8'h00, 1, 1'b0, 1'b0};
      vecs[3] = '{8'h02, 0, 1'b1, 1'b1};
      vecs[4] = '{8'hFF, 1, 1'b0, 1'b0};
      vecs[5] = '{8'hA5, 1, 1'b0, 1'b0};

      rst_n    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      vsync    = 1'b0;
      tick(3);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_front", front_bank, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_frame_done", frame_done, 0);
      rst_n = 1'b1;
      tick(2);

      // vsync and junk bytes while idle do nothing
      f0 = fd_cnt;
      e0 = err_cnt;
      pulse_vsync();
      send(8'h33);
      send(8'h01);
      tick(2);
      check("idle_vsync_fd", fd_cnt - f0, 0);
      check("idle_vsync_front", front_bank, 0);
      check("idle_junk_err", err_cnt - e0, 0);
      check("idle_junk_busy", busy, 0);

      // header table
      for (int k = 0; k < 6; k++) begin
         e0 = err_cnt;
         w0 = wr_cnt;
         send(8'hA5);
         send(vecs[k].hdr);
         tick(2);
         check($sformatf("hdr%0d_err", k), err_cnt - e0, vecs[k].exp_err);
         check($sformatf("hdr%0d_busy", k), busy, vecs[k].exp_busy);
         check($sformatf("hdr%0d_no_wr", k), wr_cnt - w0, 0);
         if (vecs[k].exp_swap) swap_expect();
      end

      // full frame into bank 1, latency-1 write check on the first pixel
      send(8'hA5);
      send(8'h01);
      send_pix(12'd0, 8'h00);
      check("lat1_wr_en", wr_en, 1);
      check("lat1_addr", wr_addr, {1'b1, 12'd0});
      for (int i = 1; i < NPIX; i++) send_pix(12'(i), 8'(i));
      tick(2);
      check("f1_busy_wait", busy, 1);
      check("f1_front_before", front_bank, 0);
      swap_expect();
      check("f1_front_after", front_bank, 1);

      // second frame lands in bank 0
      load_frame(8'h5A);
      swap_expect();
      check("f2_front_after", front_bank, 0);

      // overrun: bytes after a complete frame are dropped with err
      load_frame(8'hC3);
      e0 = err_cnt;
      w0 = wr_cnt;
      send(8'h00);
      send(8'hA5);
      send(8'h01);
      tick(2);
      check("ovr_err", err_cnt - e0, 3);
      check("ovr_no_wr", wr_cnt - w0, 0);
      check("ovr_busy", busy, 1);
      swap_expect();

      // timeout: a byte in the timeout cycle wins, then silence times out
      e0 = err_cnt;
      w0 = wr_cnt;
      send(8'hA5);
      send(8'h01);
      for (int i = 0; i < 10; i++) send_pix(12'(i), 8'(i + 100));
      tick(35000);
      send_pix(12'd10, 8'hEE);
      tick(2);
      check("to_edge_err", err_cnt - e0, 0);
      check("to_edge_busy", busy, 1);
      tick(34990);
      check("to_early_err", err_cnt - e0, 0);
      tick(20);
      check("to_err", err_cnt - e0, 1);
      check("to_busy", busy, 0);
      check("to_front", front_bank, exp_front);
      check("to_writes", wr_cnt - w0, 11);

      // next frame restarts at index 0, then reset mid-load
      send(8'hA5);
      send(8'h01);
      send_pix(12'd0, 8'h11);
      check("restart_addr", wr_addr, {~exp_front, 12'd0});
      for (int i = 1; i < 100; i++) send_pix(12'(i), 8'(i));
      tick(1);
      w0 = wr_cnt;
      rst_n = 1'b0;
      #1;
      check("mid_rst_wr_en", wr_en, 0);
      check("mid_rst_addr", wr_addr, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_front", front_bank, 0);
      sb.delete();
      exp_front = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(2);
      check("post_rst_no_wr", wr_cnt - w0, 0);
      send(8'hA5);
      send(8'h01);
      send_pix(12'd0, 8'h77);
      check("post_rst_addr", wr_addr, {1'b1, 12'd0});
      check("post_rst_data", wr_data, 8'h77);
      tick(2);
      check("final_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
